// File: rtl/seven_segment_reader.sv
// seven_segment_reader: recovers digit codes from a multiplexed
// active-low 7-seg bus. Optional macro BLANK_ERR_EN flags dark digits.
module seven_segment_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    code_err,
    output logic                    overrun
);

    typedef enum logic {SETTLE, HELD} state_t;

    logic [6:0]              r_seg_s1, r_seg_s2, r_seg_prev;
    logic [NUM_DIGITS-1:0]   r_an_s1, r_an_s2, r_an_prev;
    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [NUM_DIGITS-1:0]   r_seen;
    logic [4*NUM_DIGITS-1:0] r_slots;
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic                    r_valid;
    logic                    r_err;
    logic                    r_overrun;

    logic                    w_change;
    logic                    w_eval;
    logic [3:0]              w_code;
    logic                    w_legal;
    logic [NUM_DIGITS-1:0]   w_act;
    logic                    w_none;
    logic                    w_one;
    logic                    w_err;
    logic [NUM_DIGITS-1:0]   w_wr_vec;
    logic                    w_done;

    // Two-flop synchroniser plus a copy for change detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg_s1   <= 7'h7F;
            r_seg_s2   <= 7'h7F;
            r_seg_prev <= 7'h7F;
            r_an_s1    <= '1;
            r_an_s2    <= '1;
            r_an_prev  <= '1;
        end else begin
            r_seg_s1   <= seg_in;
            r_seg_s2   <= r_seg_s1;
            r_seg_prev <= r_seg_s2;
            r_an_s1    <= an_in;
            r_an_s2    <= r_an_s1;
            r_an_prev  <= r_an_s2;
        end
    end

    assign w_change = (r_seg_s2 != r_seg_prev) || (r_an_s2 != r_an_prev);
    assign w_eval   = (r_state == SETTLE) && !w_change &&
                      (r_cnt == CNT_W'(STABLE_CYCLES - 1));

    // Segment pattern to code; anything off-table is illegal
    always_comb begin
        w_legal = 1'b1;
        w_code  = 4'h0;
        case (r_seg_s2)
            7'h40: w_code = 4'h0;
            7'h79: w_code = 4'h1;
            7'h24: w_code = 4'h2;
            7'h30: w_code = 4'h3;
            7'h19: w_code = 4'h4;
            7'h12: w_code = 4'h5;
            7'h02: w_code = 4'h6;
            7'h78: w_code = 4'h7;
            7'h00: w_code = 4'h8;
            7'h10: w_code = 4'h9;
            7'h39: w_code = 4'hA;
            7'h3F: w_code = 4'hB;
            default: w_legal = 1'b0;
        endcase
    end

    assign w_act  = ~r_an_s2;
    assign w_none = (w_act == '0);
    assign w_one  = !w_none &&
                    ((w_act & (w_act - NUM_DIGITS'(1))) == '0);

    // Blank digits are only a fault when the dark-digit check is built in
`ifdef BLANK_ERR_EN
    assign w_err = w_eval && (!w_one || !w_legal);
`else
    assign w_err = w_eval &&
                   ((w_one && !w_legal && (r_seg_s2 != 7'h7F)) ||
                    (!w_one && !w_none));
`endif

    assign w_wr_vec = w_act &
                      {NUM_DIGITS{w_eval && w_one && w_legal}};
    assign w_done   = &r_seen;

    // Settle FSM, slot capture, frame hand-off and error flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= SETTLE;
            r_cnt     <= '0;
            r_seen    <= '0;
            r_slots   <= '0;
            r_digits  <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_err <= w_err;
            if (w_change) begin
                r_cnt   <= '0;
                r_state <= SETTLE;
            end else if (r_state == SETTLE) begin
                if (w_eval) begin
                    r_state <= HELD;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_wr_vec[i]) begin
                    r_slots[4*i +: 4] <= w_code;
                end
            end
            r_seen <= (w_done ? '0 : r_seen) | w_wr_vec;
            if (r_valid && frame_ready) begin
                r_valid <= 1'b0;
            end
            if (w_done) begin
                if (!r_valid || frame_ready) begin
                    r_digits <= r_slots;
                    r_valid  <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign digits_out  = r_digits;
    assign frame_valid = r_valid;
    assign code_err    = r_err;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_seven_segment_reader.sv
// tb_seven_segment_reader: directed vectors for the
// seven-segment bus snooper.
module tb_seven_segment_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_in = 7'h79;
    logic [3:0]  an_in = 4'b1110;
    logic [15:0] digits_out;
    logic        frame_valid;
    logic        frame_ready = 1'b1;
    logic        code_err;
    logic        overrun;

    int n_cmp = 0;
    int n_bad = 0;
    int frame_cnt = 0;
    int err_cnt = 0;
    logic [15:0] last_frame = '0;
    int e0;

`ifdef BLANK_ERR_EN
    localparam int BLANK_E = 1;
`else
    localparam int BLANK_E = 0;
`endif

    seven_segment_reader #(
        .NUM_DIGITS(4),
        .STABLE_CYCLES(16),
        .CNT_W(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .seg_in(seg_in),
        .an_in(an_in),
        .digits_out(digits_out),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .code_err(code_err),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Count accepted frames and error pulses between edges
    always @(negedge clk) begin
        if (rst_n && frame_valid && frame_ready) begin
            frame_cnt++;
            last_frame = digits_out;
        end
        if (rst_n && code_err) err_cnt++;
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic show(input logic [3:0] an,
                        input logic [6:0] seg,
                        input int n);
        @(posedge clk);
        #2;
        an_in  = an;
        seg_in = seg;
        repeat (n) @(posedge clk);
    endtask

    task automatic set_rst(input logic v);
        @(posedge clk);
        #2;
        rst_n = v;
    endtask

    initial begin
        // Reset state, bus already showing digit 0
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_digits", 32'(digits_out), 32'h0);
        chk("rst_valid", 32'(frame_valid), 32'h0);
        chk("rst_err", 32'(code_err), 32'h0);
        chk("rst_ovr", 32'(overrun), 32'h0);
        set_rst(1'b1);

        // 1) Plain frame 4321
        show(4'b1110, 7'h79, 40);
        show(4'b1101, 7'h24, 40);
        show(4'b1011, 7'h30, 40);
        show(4'b0111, 7'h19, 40);
        @(negedge clk);
        chk("t1_cnt", 32'(frame_cnt), 32'd1);
        chk("t1_frame", 32'(last_frame), 32'h4321);
        chk("t1_err", 32'(err_cnt), 32'd0);
        chk("t1_valid", 32'(frame_valid), 32'h0);

        // 2) Glitchy digit 0 never settles
        for (int k = 0; k < 5; k++) begin
            show(4'b1110, 7'h12, 9);
            show(4'b1110, 7'h13, 0);
        end
        show(4'b1110, 7'h12, 9);
        show(4'b1101, 7'h02, 40);
        show(4'b1011, 7'h30, 40);
        show(4'b0111, 7'h78, 40);
        @(negedge clk);
        chk("t2_noframe", 32'(frame_cnt), 32'd1);
        show(4'b1110, 7'h12, 25);
        @(negedge clk);
        chk("t2_cnt", 32'(frame_cnt), 32'd2);
        chk("t2_frame", 32'(last_frame), 32'h7365);

        // 3) Illegal pattern and two anodes
        e0 = err_cnt;
        show(4'b1011, 7'h55, 60);
        @(negedge clk);
        chk("t3_err1", 32'(err_cnt - e0), 32'd1);
        show(4'b0011, 7'h24, 40);
        @(negedge clk);
        chk("t3_err2", 32'(err_cnt - e0), 32'd2);
        show(4'b1110, 7'h40, 40);
        show(4'b1101, 7'h79, 40);
        show(4'b0111, 7'h19, 40);
        @(negedge clk);
        chk("t3_incomplete", 32'(frame_cnt), 32'd2);
        show(4'b1011, 7'h12, 40);
        @(negedge clk);
        chk("t3_cnt", 32'(frame_cnt), 32'd3);
        chk("t3_frame", 32'(last_frame), 32'h4510);

        // 4) Back-pressure and overrun
        @(posedge clk);
        #2;
        frame_ready = 1'b0;
        show(4'b1110, 7'h39, 40);
        show(4'b1101, 7'h3F, 40);
        show(4'b1011, 7'h00, 40);
        show(4'b0111, 7'h40, 40);
        @(negedge clk);
        chk("t4_valid", 32'(frame_valid), 32'h1);
        chk("t4_data", 32'(digits_out), 32'h08BA);
        chk("t4_ovr0", 32'(overrun), 32'h0);
        show(4'b1110, 7'h39, 40);
        show(4'b1101, 7'h3F, 40);
        show(4'b1011, 7'h00, 40);
        show(4'b0111, 7'h40, 40);
        @(negedge clk);
        chk("t4_ovr1", 32'(overrun), 32'h1);
        chk("t4_data2", 32'(digits_out), 32'h08BA);
        show(4'b1110, 7'h79, 40);
        show(4'b1101, 7'h24, 40);
        show(4'b1011, 7'h30, 40);
        show(4'b0111, 7'h19, 40);
        @(negedge clk);
        chk("t4_data3", 32'(digits_out), 32'h08BA);
        chk("t4_valid3", 32'(frame_valid), 32'h1);
        @(posedge clk);
        #2;
        frame_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t4_cnt", 32'(frame_cnt), 32'd4);
        chk("t4_frame", 32'(last_frame), 32'h08BA);
        chk("t4_drop", 32'(frame_valid), 32'h0);

        // 5) Reset mid-frame
        show(4'b1110, 7'h78, 40);
        show(4'b1101, 7'h10, 40);
        @(posedge clk);
        #2;
        rst_n  = 1'b0;
        an_in  = 4'b1011;
        seg_in = 7'h79;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("t5_digits", 32'(digits_out), 32'h0);
        chk("t5_valid", 32'(frame_valid), 32'h0);
        chk("t5_ovr", 32'(overrun), 32'h0);
        chk("t5_err", 32'(code_err), 32'h0);
        set_rst(1'b1);
        show(4'b1011, 7'h79, 40);
        show(4'b0111, 7'h24, 40);
        @(negedge clk);
        chk("t5_partial", 32'(frame_cnt), 32'd4);
        show(4'b1110, 7'h02, 40);
        show(4'b1101, 7'h00, 40);
        @(negedge clk);
        chk("t5_cnt", 32'(frame_cnt), 32'd5);
        chk("t5_frame", 32'(last_frame), 32'h2186);

        // 6) Dark digit and blank bus
        @(posedge clk);
        #2;
        rst_n  = 1'b0;
        an_in  = 4'b1101;
        seg_in = 7'h7F;
        repeat (4) @(posedge clk);
        #2;
        e0 = err_cnt;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("t6_dark", 32'(err_cnt - e0), 32'(BLANK_E));
        show(4'b1111, 7'h7F, 40);
        @(negedge clk);
        chk("t6_blank", 32'(err_cnt - e0), 32'(2 * BLANK_E));
        show(4'b1110, 7'h40, 40);
        show(4'b1011, 7'h79, 40);
        show(4'b0111, 7'h24, 40);
        @(negedge clk);
        chk("t6_nowrite", 32'(frame_cnt), 32'd5);
        chk("t6_err_end", 32'(err_cnt - e0), 32'(2 * BLANK_E));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
